// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32I memory-access stage with byte-writable data RAM
package mem_access_pkg;
  localparam int cXLEN       = 32;
  localparam int cRegSelBitW = 5;

  typedef struct packed {
    logic                   read;
    logic                   write;
    logic [cXLEN-1:0]       addr;
    logic [cXLEN-1:0]       data;
    logic [2:0]             opType;
    logic [cRegSelBitW-1:0] rdAddr;
  } tMemOp;

  typedef struct packed {
    logic                   dv;
    logic [cRegSelBitW-1:0] addr;
    logic [cXLEN-1:0]       data;
  } tRegOp;
endpackage

module mem_access_stage
  import mem_access_pkg::*;
#(
  parameter int cRamDepth = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  tMemOp       iMemOp,
  input  tRegOp       iRegOp,
  output tRegOp       oRegOp,
  output logic        oLoadPend,
  output logic [cRegSelBitW-1:0] oLoadRd,
  output logic        oMisalign,
  output logic        oConflict,
  output logic [31:0] oLoadCnt,
  output logic [31:0] oStoreCnt
);
  localparam int IdxW = $clog2(cRamDepth);

  logic [cXLEN-1:0] mem [cRamDepth];
  logic [cXLEN-1:0] rdata;
  logic [cXLEN-1:0] wdata;
  logic [cXLEN-1:0] shifted;
  logic [cXLEN-1:0] ld_data;
  logic [IdxW-1:0]  idx;
  logic [1:0]       off;
  logic [3:0]       be;
  logic             ld_ok;
  logic             st_ok;
  logic             do_load;
  logic             do_store;
  logic             misalign;
  logic             conflict;

  logic                   ld_pend;
  logic [cRegSelBitW-1:0] ld_rd;
  logic [2:0]             ld_type;
  logic [1:0]             ld_off;
  tRegOp                  reg_q;

  // Upper address bits alias onto the RAM.
  logic unused_addr;
  assign unused_addr = ^iMemOp.addr[cXLEN-1:IdxW+2];

  assign off   = iMemOp.addr[1:0];
  assign idx   = iMemOp.addr[IdxW+1:2];
  assign wdata = iMemOp.data << {off, 3'b000};

  always_comb begin
    ld_ok = 1'b0;
    st_ok = 1'b0;
    be    = 4'b1111;
    case (iMemOp.opType)
      3'b000:  begin ld_ok = 1'b1;       st_ok = 1'b1;       be = 4'b0001 << off; end
      3'b001:  begin ld_ok = ~off[0];    st_ok = ~off[0];    be = 4'b0011 << off; end
      3'b010:  begin ld_ok = (off == 2'b00); st_ok = (off == 2'b00); end
      3'b100:  ld_ok = 1'b1;
      3'b101:  ld_ok = ~off[0];
      default: ;
    endcase
  end

  // A store presented while reset is asserted must not touch the RAM.
  assign do_load  = iMemOp.read & ~iMemOp.write & ld_ok;
  assign do_store = rstn & iMemOp.write & ~iMemOp.read & st_ok;
  assign misalign = (iMemOp.read & ~iMemOp.write & ~ld_ok) |
                    (iMemOp.write & ~iMemOp.read & ~st_ok);
  assign conflict = (iMemOp.read & iMemOp.write) | (do_load & iRegOp.dv);

  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (do_load) rdata <= mem[idx];
  end

  assign shifted = rdata >> {ld_off, 3'b000};

  always_comb begin
    case (ld_type)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {24'd0, shifted[7:0]};
      3'b101:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ld_pend   <= 1'b0;
      ld_rd     <= '0;
      ld_type   <= '0;
      ld_off    <= '0;
      reg_q     <= '0;
      oRegOp    <= '0;
      oMisalign <= 1'b0;
      oConflict <= 1'b0;
      oLoadCnt  <= '0;
      oStoreCnt <= '0;
    end else begin
      ld_pend    <= do_load;
      ld_rd      <= do_load ? iMemOp.rdAddr : '0;
      ld_type    <= iMemOp.opType;
      ld_off     <= off;
      // A load in the same cycle owns the writeback slot; the ALU result is dropped.
      reg_q.dv   <= iRegOp.dv & (iRegOp.addr != '0) & ~do_load;
      reg_q.addr <= iRegOp.addr;
      reg_q.data <= iRegOp.data;
      oMisalign  <= misalign;
      oConflict  <= conflict;
      if (ld_pend) begin
        oRegOp.dv   <= (ld_rd != '0);
        oRegOp.addr <= ld_rd;
        oRegOp.data <= ld_data;
        oLoadCnt    <= oLoadCnt + 32'd1;
      end else begin
        oRegOp <= reg_q;
      end
      if (do_store) oStoreCnt <= oStoreCnt + 32'd1;
    end
  end

  assign oLoadPend = ld_pend;
  assign oLoadRd   = ld_rd;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage
module tb_mem_access_stage;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  tMemOp       mem_op;
  tRegOp       reg_in;
  tRegOp       reg_out;
  logic        load_pend;
  logic [4:0]  load_rd;
  logic        misalign;
  logic        conflict;
  logic [31:0] load_cnt;
  logic [31:0] store_cnt;

  int    pass_cnt  = 0;
  int    total_cnt = 0;
  tRegOp exp_q[$];
  tRegOp mon_exp;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk       (clk),
    .rstn      (rstn),
    .iMemOp    (mem_op),
    .iRegOp    (reg_in),
    .oRegOp    (reg_out),
    .oLoadPend (load_pend),
    .oLoadRd   (load_rd),
    .oMisalign (misalign),
    .oConflict (conflict),
    .oLoadCnt  (load_cnt),
    .oStoreCnt (store_cnt)
  );

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  function automatic tMemOp mop(logic rd, logic wr, logic [31:0] a, logic [31:0] d,
                                logic [2:0] t, logic [4:0] r);
    tMemOp m;
    m.read = rd; m.write = wr; m.addr = a; m.data = d; m.opType = t; m.rdAddr = r;
    return m;
  endfunction

  function automatic tRegOp rop(logic v, logic [4:0] a, logic [31:0] d);
    tRegOp r;
    r.dv = v; r.addr = a; r.data = d;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  task automatic step(tMemOp m, tRegOp r);
    mem_op = m;
    reg_in = r;
    @(posedge clk);
    #1;
    mem_op = '0;
    reg_in = '0;
  endtask

  task automatic idle(int n);
    repeat (n) step('0, '0);
  endtask

  task automatic store(logic [31:0] a, logic [31:0] d, logic [2:0] t);
    step(mop(1'b0, 1'b1, a, d, t, 5'd0), '0);
  endtask

  task automatic load(logic [31:0] a, logic [2:0] t, logic [4:0] rd, logic [31:0] exp);
    if (rd != 5'd0) exp_q.push_back(rop(1'b1, rd, exp));
    step(mop(1'b1, 1'b0, a, 32'd0, t, rd), '0);
  endtask

  // Every writeback the DUT presents must match the oldest expected entry.
  always @(negedge clk) begin
    if (reg_out.dv) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_writeback: got addr %0d data 0x%08h required none",
                 reg_out.addr, reg_out.data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (reg_out === mon_exp) pass_cnt++;
        else $display("FAIL writeback: got {%0d,%0d,0x%08h} required {%0d,%0d,0x%08h}",
                      reg_out.dv, reg_out.addr, reg_out.data,
                      mon_exp.dv, mon_exp.addr, mon_exp.data);
      end
    end
  end

  initial begin
    mem_op = '0;
    reg_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dv", reg_out.dv, 0);
    check("rst_addr", reg_out.addr, 0);
    check("rst_data", reg_out.data, 0);
    check("rst_pend", load_pend, 0);
    check("rst_rd", load_rd, 0);
    check("rst_misalign", misalign, 0);
    check("rst_conflict", conflict, 0);
    check("rst_ldcnt", load_cnt, 0);
    check("rst_stcnt", store_cnt, 0);
    rstn = 1'b1;

    store(32'h10, 32'h8765_4321, LW);
    load(32'h10, LW, 5'd5, 32'h8765_4321);
    @(negedge clk);
    check("lw_pend", load_pend, 1);
    check("lw_rd", load_rd, 5);
    idle(2);
    check("cnt1_ld", load_cnt, 1);
    check("cnt1_st", store_cnt, 1);
    check("idle_pend", load_pend, 0);
    check("idle_rd", load_rd, 0);

    load(32'h13, LB, 5'd6, 32'hFFFF_FF87);
    load(32'h13, LBU, 5'd7, 32'h0000_0087);
    @(negedge clk);
    check("b2b_pend", load_pend, 1);
    load(32'h12, LH, 5'd8, 32'hFFFF_8765);
    load(32'h10, LHU, 5'd9, 32'h0000_4321);
    idle(2);

    store(32'h11, 32'h1234_56AA, LB);
    load(32'h10, LW, 5'd10, 32'h8765_AA21);
    store(32'h12, 32'h0000_BEEF, LH);
    load(32'h10, LW, 5'd11, 32'hBEEF_AA21);
    idle(2);
    check("cnt2_ld", load_cnt, 7);
    check("cnt2_st", store_cnt, 3);

    step(mop(1'b1, 1'b0, 32'h11, 32'd0, LH, 5'd12), '0);
    @(negedge clk);
    check("mis_lh", misalign, 1);
    store(32'h12, 32'hDEAD_BEEF, LW);
    @(negedge clk);
    check("mis_sw", misalign, 1);
    idle(1);
    check("mis_pulse_end", misalign, 0);
    step(mop(1'b1, 1'b0, 32'h10, 32'd0, 3'b011, 5'd12), '0);
    @(negedge clk);
    check("mis_badop", misalign, 1);
    idle(2);
    check("cnt3_ld", load_cnt, 7);
    check("cnt3_st", store_cnt, 3);
    load(32'h10, LW, 5'd13, 32'hBEEF_AA21);

    exp_q.push_back(rop(1'b1, 5'd7, 32'hBEEF_AA21));
    step(mop(1'b1, 1'b0, 32'h10, 32'd0, LW, 5'd7), rop(1'b1, 5'd9, 32'h55));
    @(negedge clk);
    check("cf_ldreg", conflict, 1);
    check("cf_pend", load_pend, 1);
    check("cf_rd", load_rd, 7);
    step(mop(1'b1, 1'b1, 32'h10, 32'h1111_1111, LW, 5'd14), '0);
    @(negedge clk);
    check("cf_rdwr", conflict, 1);
    check("cf_rdwr_pend", load_pend, 0);
    idle(1);
    check("cf_pulse_end", conflict, 0);
    load(32'h10, LW, 5'd15, 32'hBEEF_AA21);

    exp_q.push_back(rop(1'b1, 5'd9, 32'h55));
    step('0, rop(1'b1, 5'd9, 32'h55));
    step('0, rop(1'b1, 5'd0, 32'h77));
    step(mop(1'b1, 1'b0, 32'h10, 32'd0, LW, 5'd0), '0);
    idle(2);
    check("cnt4_ld", load_cnt, 11);
    check("cnt4_st", store_cnt, 3);

    step(mop(1'b1, 1'b0, 32'h10, 32'd0, LW, 5'd3), '0);
    rstn = 1'b0;
    mem_op = mop(1'b0, 1'b1, 32'h10, 32'h9999_9999, LW, 5'd0);
    @(posedge clk);
    #1;
    mem_op = '0;
    rstn = 1'b1;
    @(negedge clk);
    check("rst2_dv", reg_out.dv, 0);
    check("rst2_data", reg_out.data, 0);
    check("rst2_pend", load_pend, 0);
    check("rst2_ldcnt", load_cnt, 0);
    check("rst2_stcnt", store_cnt, 0);
    idle(2);

    load(32'h1010, LW, 5'd4, 32'hBEEF_AA21);
    store(32'h1010, 32'hCAFE_F00D, LW);
    load(32'h10, LW, 5'd5, 32'hCAFE_F00D);
    idle(3);
    check("cnt5_ld", load_cnt, 2);
    check("cnt5_st", store_cnt, 1);
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
